proc_cfg_master: RTL and testbench

PROC_CFG_MASTER -- requirements
Module: proc_cfg_master

---
 rtl/proc_regs_pkg.sv | 23 ++
 rtl/proc_cfg_master.sv | 132 +++++++++++++
 tb/tb_proc_cfg_master.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_regs_pkg.sv
// Register map, processor constants and controller state type shared by the
// configuration master and the data_processor tests.
package proc_regs_pkg;

  localparam logic [4:0] ADDR_MODE    = 5'h00;
  localparam logic [4:0] ADDR_KERN0   = 5'h04;
  localparam logic [4:0] ADDR_STATUS  = 5'h10;

  localparam logic [7:0] STATUS_MAGIC = 8'hAA;
  localparam int         NUM_TAPS     = 9;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHK_STAT = 3'd1,
    WR_BYP   = 3'd2,
    WR_KERN  = 3'd3,
    WR_MODE  = 3'd4,
    RD_KERN  = 3'd5,
    RD_MODE  = 3'd6,
    DONE     = 3'd7
  } state_t;

endpackage

// File: rtl/proc_cfg_master.sv
// Programs the data processor: status check, bypass, kernel taps and mode,
// with optional readback verification and first-failure address capture.
module proc_cfg_master
  import proc_regs_pkg::*;
#(
  parameter logic [7:0] STATUS_MAGIC = proc_regs_pkg::STATUS_MAGIC,
  parameter int         NUM_TAPS     = proc_regs_pkg::NUM_TAPS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [8*NUM_TAPS-1:0] cfg_kernel,
  input  logic                  verify_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [4:0]            err_addr,
  output logic                  reg_write_en,
  output logic [4:0]            reg_addr,
  output logic [7:0]            reg_wdata,
  input  logic [7:0]            reg_rdata,
  output state_t                fsm_state
);

  // Register port: reg_write_en qualifies a write of reg_wdata to reg_addr on
  // the rising edge; reads are combinational, reg_rdata is checked in the
  // same cycle its reg_addr is driven.

  localparam logic [3:0] LAST_TAP = 4'(NUM_TAPS - 1);

  state_t                state, state_nxt;
  logic [3:0]            tap;
  logic [1:0]            mode_q;
  logic [8*NUM_TAPS-1:0] kernel_q;
  logic                  verify_q;
  logic [6:0]            tap_bit;
  logic [7:0]            tap_data;
  logic [7:0]            exp_rdata;
  logic                  rd_check;

  assign tap_bit   = {tap, 3'b000};
  assign tap_data  = kernel_q[tap_bit +: 8];
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      tap      <= '0;
      mode_q   <= '0;
      kernel_q <= '0;
      verify_q <= 1'b0;
      error    <= 1'b0;
      err_addr <= '0;
    end else begin
      state <= state_nxt;
      // Idles at zero outside the tap loops, so each loop enters at tap 0.
      tap   <= ((state == WR_KERN || state == RD_KERN) && tap != LAST_TAP) ? tap + 4'd1 : '0;
      if (state == IDLE && start) begin
        mode_q   <= cfg_mode;
        kernel_q <= cfg_kernel;
        verify_q <= verify_en;
        error    <= 1'b0;
        err_addr <= '0;
      end
      if (state == CHK_STAT && reg_rdata != STATUS_MAGIC) begin
        error    <= 1'b1;
        err_addr <= ADDR_STATUS;
      end
      if (rd_check && reg_rdata != exp_rdata) begin
        error <= 1'b1;
        if (!error) err_addr <= reg_addr;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    busy         = 1'b1;
    done         = 1'b0;
    reg_write_en = 1'b0;
    reg_addr     = '0;
    reg_wdata    = '0;
    rd_check     = 1'b0;
    exp_rdata    = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CHK_STAT;
      end
      CHK_STAT: begin
        reg_addr  = ADDR_STATUS;
        state_nxt = (reg_rdata == STATUS_MAGIC) ? WR_BYP : DONE;
      end
      WR_BYP: begin
        reg_write_en = 1'b1;
        reg_addr     = ADDR_MODE;
        state_nxt    = WR_KERN;
      end
      WR_KERN: begin
        reg_write_en = 1'b1;
        reg_addr     = ADDR_KERN0 + {1'b0, tap};
        reg_wdata    = tap_data;
        if (tap == LAST_TAP) state_nxt = WR_MODE;
      end
      WR_MODE: begin
        reg_write_en = 1'b1;
        reg_addr     = ADDR_MODE;
        reg_wdata    = {6'b0, mode_q};
        state_nxt    = verify_q ? RD_KERN : DONE;
      end
      RD_KERN: begin
        reg_addr  = ADDR_KERN0 + {1'b0, tap};
        rd_check  = 1'b1;
        exp_rdata = tap_data;
        if (tap == LAST_TAP) state_nxt = RD_MODE;
      end
      RD_MODE: begin
        reg_addr  = ADDR_MODE;
        rd_check  = 1'b1;
        exp_rdata = {6'b0, mode_q};
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_proc_cfg_master.sv
// Bench for proc_cfg_master driving a behavioural data processor register file
// with a configurable status value and read-corruption mask.
module tb_proc_cfg_master;
  import proc_regs_pkg::*;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   cfg_mode = '0;
  logic [71:0]  cfg_kernel = '0;
  logic         verify_en = 1'b0;
  logic         busy, done, error, reg_write_en;
  logic [4:0]   err_addr, reg_addr;
  logic [7:0]   reg_wdata, reg_rdata;
  state_t       fsm_state;

  // processor model
  logic [7:0]   regs [32];
  logic [7:0]   status_val = 8'hAA;
  logic [31:0]  corrupt_mask = '0;

  int checks = 0, errors = 0;
  logic [12:0] wr_q[$], exp_q[$];
  logic [4:0]  rd_q[$], exp_rd_q[$];
  int          done_cyc, done_cnt, exp_done, post_rst_wr, post_rst_busy;
  logic        obs_err, exp_err, err_end;
  logic [4:0]  obs_err_addr, exp_err_addr;

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_write_en) regs[reg_addr] <= reg_wdata;

  always_comb begin
    reg_rdata = regs[reg_addr] ^ (corrupt_mask[reg_addr] ? 8'hFF : 8'h00);
    if (reg_addr == 5'h10) reg_rdata = status_val;
  end

  proc_cfg_master dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_mode(cfg_mode), .cfg_kernel(cfg_kernel),
    .verify_en(verify_en), .busy(busy), .done(done), .error(error), .err_addr(err_addr),
    .reg_write_en(reg_write_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .fsm_state(fsm_state)
  );

  // Reference: the transaction list a run must produce, from the register map rules.
  task automatic build_model(input logic [71:0] k, input logic [1:0] m, input logic v);
    exp_q.delete(); exp_rd_q.delete();
    exp_err = 1'b0; exp_err_addr = '0;
    exp_rd_q.push_back(5'h10);
    if (status_val != 8'hAA) begin
      exp_err = 1'b1; exp_err_addr = 5'h10; exp_done = 2;
      return;
    end
    exp_q.push_back({5'h00, 8'h00});
    for (int i = 0; i < 9; i++) exp_q.push_back({5'(4 + i), k[8*i +: 8]});
    exp_q.push_back({5'h00, 6'b0, m});
    exp_done = v ? 23 : 13;
    if (v) begin
      for (int i = 0; i < 9; i++) exp_rd_q.push_back(5'(4 + i));
      exp_rd_q.push_back(5'h00);
      for (int i = 1; i < exp_rd_q.size(); i++)
        if (corrupt_mask[exp_rd_q[i]] && !exp_err) begin
          exp_err = 1'b1; exp_err_addr = exp_rd_q[i];
        end
    end
  endtask

  task automatic launch(input logic [71:0] k, input logic [1:0] m, input logic v);
    @(negedge clk);
    cfg_kernel = k; cfg_mode = m; verify_en = v; start = 1'b1;
    @(posedge clk);
  endtask

  // Observe ncyc cycles after the accept edge; scramble cfg_* to prove shadowing.
  task automatic watch(input int ncyc, input int pulse_at, input int rst_at);
    wr_q.delete(); rd_q.delete();
    done_cyc = 0; done_cnt = 0; obs_err = 0; obs_err_addr = '0; post_rst_wr = 0; post_rst_busy = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (reg_write_en) begin
        wr_q.push_back({reg_addr, reg_wdata});
        if (rst_at > 0 && c > rst_at) post_rst_wr++;
      end else if (busy && !done) rd_q.push_back(reg_addr);
      if (rst_at > 0 && c > rst_at && busy) post_rst_busy++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin done_cyc = c; obs_err = error; obs_err_addr = err_addr; end
      end
      err_end = error;
      start = (pulse_at > 0 && c == pulse_at);
      if (rst_at > 0) rstn = !(c >= rst_at && c < rst_at + 2);
      cfg_kernel = {$urandom, $urandom, 8'($urandom)};
      cfg_mode = 2'($urandom); verify_en = 1'($urandom);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, reg_write_en} !== 4'b0 || err_addr !== 5'h0 || reg_addr !== 5'h0 ||
        reg_wdata !== 8'h0 || fsm_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b error=%b we=%b err_addr=%h addr=%h wdata=%h state=%0d expected all zero/IDLE",
               busy, done, error, reg_write_en, err_addr, reg_addr, reg_wdata, fsm_state);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_verify_run;
    logic [71:0] k;
    for (int i = 0; i < 9; i++) k[8*i +: 8] = 8'(i + 1);
    status_val = 8'hAA; corrupt_mask = '0;
    build_model(k, 2'b10, 1'b1);
    launch(k, 2'b10, 1'b1);
    watch(30, 0, 0);
    checks++;
    if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL verify_run write count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL verify_run write %0d: got %h expected %h", i, (i < wr_q.size()) ? wr_q[i] : 13'h1fff, exp_q[i]); end
    end
    checks++;
    if (rd_q != exp_rd_q) begin errors++; $display("FAIL verify_run reads: got %0d reads expected %0d", rd_q.size(), exp_rd_q.size()); end
    checks++;
    if (done_cyc != exp_done || done_cnt != 1) begin errors++; $display("FAIL verify_run done: got cycle %0d count %0d expected cycle %0d count 1", done_cyc, done_cnt, exp_done); end
    checks++;
    if (obs_err !== 1'b0) begin errors++; $display("FAIL verify_run error: got %b expected 0", obs_err); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (regs[4 + i] !== k[8*i +: 8]) begin errors++; $display("FAIL verify_run proc tap %0d: got %h expected %h", i, regs[4 + i], k[8*i +: 8]); end
    end
    checks++;
    if (regs[0] !== 8'h02) begin errors++; $display("FAIL verify_run proc mode: got %h expected 02", regs[0]); end
  endtask

  task automatic test_no_verify;
    logic [71:0] k;
    for (int i = 0; i < 9; i++) k[8*i +: 8] = 8'(i + 1);
    status_val = 8'hAA; corrupt_mask = '0;
    build_model(k, 2'b10, 1'b0);
    launch(k, 2'b10, 1'b0);
    watch(30, 0, 0);
    checks++;
    if (wr_q.size() != 11) begin errors++; $display("FAIL no_verify write count: got %0d expected 11", wr_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL no_verify write %0d: got %h expected %h", i, (i < wr_q.size()) ? wr_q[i] : 13'h1fff, exp_q[i]); end
    end
    checks++;
    if (rd_q != exp_rd_q) begin errors++; $display("FAIL no_verify reads: got %0d reads expected %0d", rd_q.size(), exp_rd_q.size()); end
    checks++;
    if (done_cyc != 13 || done_cnt != 1) begin errors++; $display("FAIL no_verify done: got cycle %0d count %0d expected cycle 13 count 1", done_cyc, done_cnt); end
    checks++;
    if (obs_err !== 1'b0) begin errors++; $display("FAIL no_verify error: got %b expected 0", obs_err); end
  endtask

  task automatic test_status_abort;
    logic [71:0] k;
    k = {$urandom, $urandom, 8'($urandom)};
    status_val = 8'h55; corrupt_mask = '0;
    build_model(k, 2'b01, 1'b1);
    launch(k, 2'b01, 1'b1);
    watch(30, 0, 0);
    checks++;
    if (wr_q.size() != 0) begin errors++; $display("FAIL status_abort writes: got %0d expected 0", wr_q.size()); end
    checks++;
    if (done_cyc != 2 || done_cnt != 1) begin errors++; $display("FAIL status_abort done: got cycle %0d count %0d expected cycle 2 count 1", done_cyc, done_cnt); end
    checks++;
    if (obs_err !== 1'b1 || obs_err_addr !== 5'h10) begin errors++; $display("FAIL status_abort error: got %b addr %h expected 1 addr 10", obs_err, obs_err_addr); end
    checks++;
    if (err_end !== 1'b1) begin errors++; $display("FAIL status_abort sticky: got error %b after idle expected 1", err_end); end
    status_val = 8'hAA;
  endtask

  task automatic test_readback_corrupt;
    logic [71:0] k;
    k = {$urandom, $urandom, 8'($urandom)};
    status_val = 8'hAA; corrupt_mask = (32'd1 << 6) | (32'd1 << 9);
    build_model(k, 2'b11, 1'b1);
    launch(k, 2'b11, 1'b1);
    watch(30, 0, 0);
    checks++;
    if (rd_q != exp_rd_q || rd_q.size() != 11) begin errors++; $display("FAIL corrupt reads: got %0d reads expected 11 (status + 10)", rd_q.size()); end
    checks++;
    if (obs_err !== 1'b1 || obs_err_addr !== 5'h06) begin errors++; $display("FAIL corrupt error: got %b addr %h expected 1 addr 06", obs_err, obs_err_addr); end
    checks++;
    if (done_cyc != 23) begin errors++; $display("FAIL corrupt done: got cycle %0d expected 23", done_cyc); end
    corrupt_mask = '0;
  endtask

  task automatic test_reset_mid_run;
    logic [71:0] k;
    k = {$urandom, $urandom, 8'($urandom)};
    status_val = 8'hAA; corrupt_mask = '0;
    build_model(k, 2'b01, 1'b1);
    while (exp_q.size() > 6) void'(exp_q.pop_back());
    launch(k, 2'b01, 1'b1);
    watch(20, 0, 7);
    checks++;
    if (wr_q != exp_q) begin errors++; $display("FAIL reset_mid writes: got %0d writes expected %0d before reset", wr_q.size(), exp_q.size()); end
    checks++;
    if (post_rst_wr != 0 || post_rst_busy != 0) begin errors++; $display("FAIL reset_mid after reset: got %0d writes %0d busy cycles expected 0 0", post_rst_wr, post_rst_busy); end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL reset_mid done: got %0d pulses expected 0", done_cnt); end
    k = {$urandom, $urandom, 8'($urandom)};
    build_model(k, 2'b10, 1'b1);
    launch(k, 2'b10, 1'b1);
    watch(30, 0, 0);
    checks++;
    if (wr_q != exp_q || rd_q != exp_rd_q) begin errors++; $display("FAIL reset_mid rerun traffic: got %0d writes %0d reads expected %0d %0d", wr_q.size(), rd_q.size(), exp_q.size(), exp_rd_q.size()); end
    checks++;
    if (done_cyc != 23 || done_cnt != 1 || obs_err !== 1'b0) begin errors++; $display("FAIL reset_mid rerun done: got cycle %0d count %0d err %b expected 23 1 0", done_cyc, done_cnt, obs_err); end
  endtask

  task automatic test_start_ignored;
    logic [71:0] k;
    k = {$urandom, $urandom, 8'($urandom)};
    status_val = 8'hAA; corrupt_mask = '0;
    build_model(k, 2'b01, 1'b1);
    launch(k, 2'b01, 1'b1);
    watch(40, 5, 0);
    checks++;
    if (done_cnt != 1 || done_cyc != 23) begin errors++; $display("FAIL start_ignored done: got count %0d cycle %0d expected 1 23", done_cnt, done_cyc); end
    checks++;
    if (wr_q != exp_q) begin errors++; $display("FAIL start_ignored writes: got %0d expected %0d", wr_q.size(), exp_q.size()); end
  endtask

  task automatic test_random_runs;
    logic [71:0] k;
    logic [1:0]  m;
    logic        v;
    int          idx;
    for (int r = 0; r < 8; r++) begin
      k = {$urandom, $urandom, 8'($urandom)};
      m = 2'($urandom); v = 1'($urandom);
      idx = $urandom_range(0, 9);
      corrupt_mask = ($urandom_range(0, 1) == 1) ? (32'd1 << ((idx == 9) ? 0 : 4 + idx)) : 32'd0;
      status_val = ($urandom_range(0, 7) == 0) ? 8'(($urandom_range(0, 254) + 8'hAB)) : 8'hAA;
      build_model(k, m, v);
      launch(k, m, v);
      watch(30, 0, 0);
      checks++;
      if (wr_q != exp_q) begin errors++; $display("FAIL random %0d writes: got %0d expected %0d", r, wr_q.size(), exp_q.size()); end
      checks++;
      if (rd_q != exp_rd_q) begin errors++; $display("FAIL random %0d reads: got %0d expected %0d", r, rd_q.size(), exp_rd_q.size()); end
      checks++;
      if (done_cyc != exp_done || done_cnt != 1) begin errors++; $display("FAIL random %0d done: got cycle %0d count %0d expected %0d 1", r, done_cyc, done_cnt, exp_done); end
      checks++;
      if (obs_err !== exp_err || obs_err_addr !== exp_err_addr) begin errors++; $display("FAIL random %0d error: got %b addr %h expected %b addr %h", r, obs_err, obs_err_addr, exp_err, exp_err_addr); end
    end
    status_val = 8'hAA; corrupt_mask = '0;
  endtask

  initial begin
    test_reset();
    test_verify_run();
    test_no_verify();
    test_status_abort();
    test_readback_corrupt();
    test_reset_mid_run();
    test_start_ignored();
    test_random_runs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
